pc_stack_register: RTL
======================

Name: pc_stack_register

Overview:
Parametrised successor to the team's 8-bit special-purpose register, used as the processor's program counter. Supports:
- synchronous load, increment and relative branch;
- a call/return address stack of configurable depth.

It sits between the control unit (which issues the command strobes) and instruction memory (which is addressed by data_out).

Parameters:
WIDTH, 8, register and address width in bits (>=2)
DEPTH, 4, return-stack entries (power of two, >=2)
RESET_VAL, 0, value loaded into data_out on reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
data_in  in  WIDTH  target for load and call
offset  in  WIDTH  two's-complement branch offset
load  in  1  load data_in
inc  in  1  increment by 1
branch  in  1  add offset
call  in  1  push return address, jump to data_in
ret  in  1  pop return address
data_out  out  WIDTH  current register value (registered)
depth_cnt  out  $clog2(DEPTH)+1  stack occupancy, 0..DEPTH
empty  out  1  depth_cnt==0 (combinational from depth_cnt)
full  out  1  depth_cnt==DEPTH (combinational from depth_cnt)
err  out  1  sticky stack error (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high):
  - data_out=RESET_VAL, depth_cnt=0, stack pointer=0, err=0.
  - Stack contents are don't-care after reset.
  - Assertion mid-operation aborts any command in the same cycle.
- All other updates occur on the rising edge of clk. Single-cycle latency: the effect is visible on data_out the cycle after the strobe.
- Priority per cycle: call > ret > branch > load > inc > hold. Exactly one command executes; lower-priority strobes are ignored.
- inc: data_out <= data_out+1, wrapping modulo 2^WIDTH (all-ones -> 0).
- branch: data_out <= data_out+offset, modulo 2^WIDTH; offset is sign-interpreted.
- load: data_out <= data_in.
- call (not full): stack[sp] <= data_out+1 (wrapped); sp++, depth_cnt++; data_out <= data_in.
- ret (not empty): sp--, depth_cnt--; data_out <= stack[sp-1].
- Stack is LIFO. Storage is a DEPTH x WIDTH register array; sp wraps modulo DEPTH.
- call and ret in the same cycle: call executes, ret is dropped.
- No strobes: all state holds.
- Boundary cases without the macro:
  - call when full: overwrites the oldest entry circularly; sp advances; depth_cnt stays DEPTH; data_out <= data_in.
  - ret when empty: no-op; data_out, sp and depth_cnt hold.
  - err is tied to 0.

Optional Feature:
Macro: PC_STACK_ERR_EN
- Defined:
  - call when full is fully suppressed: no push, data_out holds, err <= 1.
  - ret when empty is suppressed: err <= 1.
  - err is sticky and is cleared only by rst.
- Not defined: circular overwrite / no-op behaviour as described above; err is constant 0.

Test Plan:
- Reset and increment: rst pulse, RESET_VAL=0, then 3 cycles of inc -> data_out 0,1,2,3; rst asserted asynchronously mid-clock -> data_out=0 immediately.
- Wrap and branch (WIDTH=8):
  - load 8'hFE, then inc twice -> FF, 00.
  - load 8'h10, branch with offset 8'hFC -> 8'h0C.
- Priority: load=1, inc=1, branch=1 with data_in=8'h40, offset=5, data_out=8'h20 -> branch wins, data_out=8'h25. call+ret together -> call executes.
- Nested call/return (DEPTH=4):
  - sequence: data_out=8'h05, call to 8'h30, call to 8'h50, then ret, ret;
  - data_out: 30, 50, 31, 06;
  - depth_cnt: 1, 2, 1, 0;
  - empty=1 at the end.
- Overflow (DEPTH=4): five calls from 8'h00 with targets 8'h10, 8'h20, 8'h30, 8'h40, 8'h50.
  - Without macro: full=1; the fifth call jumps to 8'h50; four rets return 41, 31, 21, 11; a further ret is a no-op.
  - With PC_STACK_ERR_EN: the fifth call holds data_out=8'h40 and sets err=1; err stays 1 until rst.
- Underflow: ret with empty=1.
  - Without macro: data_out unchanged, depth_cnt=0.
  - With PC_STACK_ERR_EN: err=1, data_out unchanged.

Source files
------------

// File: rtl/pc_stack_register.sv
// rtl/pc_stack_register.sv - program counter with load/inc/branch and a call/return stack (optional PC_STACK_ERR_EN)
module pc_stack_register #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [WIDTH-1:0]           offset,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       branch,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH):0]     depth_cnt,
    output logic                       empty,
    output logic                       full,
    output logic                       err
);

    localparam int SP_W  = $clog2(DEPTH);
    localparam int CNT_W = SP_W + 1;

    // Return-address storage; contents are meaningless until pushed.
    logic [WIDTH-1:0] stack [DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_m1;
    logic [WIDTH-1:0] ret_link;

    logic [WIDTH-1:0] pc_nxt;
    logic [SP_W-1:0]  sp_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_push;
`ifdef PC_STACK_ERR_EN
    logic             err_set;
    logic             err_q;
`endif

    assign empty    = (depth_cnt == '0);
    assign full     = (depth_cnt == CNT_W'(DEPTH));
    assign sp_m1    = sp - SP_W'(1);
    assign ret_link = data_out + WIDTH'(1);

    // Resolve the single winning command for this cycle: call > ret > branch > load > inc.
    always_comb begin
        pc_nxt  = data_out;
        sp_nxt  = sp;
        cnt_nxt = depth_cnt;
        do_push = 1'b0;
`ifdef PC_STACK_ERR_EN
        err_set = 1'b0;
`endif
        if (call) begin
            if (full) begin
`ifdef PC_STACK_ERR_EN
                // Overflow is refused outright and flagged.
                err_set = 1'b1;
`else
                // Overflow recycles the oldest slot; occupancy saturates at DEPTH.
                do_push = 1'b1;
                sp_nxt  = sp + SP_W'(1);
                pc_nxt  = data_in;
`endif
            end else begin
                do_push = 1'b1;
                sp_nxt  = sp + SP_W'(1);
                cnt_nxt = depth_cnt + CNT_W'(1);
                pc_nxt  = data_in;
            end
        end else if (ret) begin
            if (empty) begin
`ifdef PC_STACK_ERR_EN
                err_set = 1'b1;
`endif
            end else begin
                sp_nxt  = sp_m1;
                cnt_nxt = depth_cnt - CNT_W'(1);
                pc_nxt  = stack[sp_m1];
            end
        end else if (branch) begin
            pc_nxt = data_out + offset;
        end else if (load) begin
            pc_nxt = data_in;
        end else if (inc) begin
            pc_nxt = data_out + WIDTH'(1);
        end
    end

    // Program counter, stack pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= RESET_VAL;
            sp        <= '0;
            depth_cnt <= '0;
        end else begin
            data_out  <= pc_nxt;
            sp        <= sp_nxt;
            depth_cnt <= cnt_nxt;
        end
    end

    // Stack write of the return link; a reset in the same cycle cancels the push.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            stack[sp] <= ret_link;
        end
    end

`ifdef PC_STACK_ERR_EN
    // Sticky overflow/underflow flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
